// File: rtl/program_loader.sv
// Packs a UART byte stream into instruction words and writes them to
// consecutive instruction-memory addresses until HALT or the last location.
module program_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_BYTE        = 8,
  parameter int                 NB_ADDR_CUSTOM = 5,
  parameter int                 ROM_DEPTH      = 30,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_wr_enable,
  output logic [NB_ADDR_CUSTOM-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]        o_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overrun,
  output logic [NB_ADDR_CUSTOM:0]   o_word_count
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int CW = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB_BYTES - 1);
  localparam logic [NB_ADDR_CUSTOM-1:0] LAST_ADDR =
    NB_ADDR_CUSTOM'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             bcnt_q, bcnt_d;
  logic [NB_DATA-1:0]        word_q, word_d;
  logic [NB_ADDR_CUSTOM-1:0] addr_q, addr_d;
  logic [NB_ADDR_CUSTOM:0]   cnt_q, cnt_d;
  logic                      ovr_q, ovr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        bcnt_d = '0;
        ovr_d  = 1'b0;
        if (i_start) state_d = RECEIVE;
      end
      RECEIVE: begin
        if (i_rx_valid) begin
          // big-endian: first byte ends up in the MSB
          word_d = NB_DATA'({word_q, i_rx_data});
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (i_rx_valid) ovr_d = 1'b1;
        if (word_q == HALT_WORD || addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECEIVE;
        end
      end
      DONE: begin
        if (i_start) begin
          addr_d  = '0;
          cnt_d   = '0;
          bcnt_d  = '0;
          ovr_d   = 1'b0;
          state_d = RECEIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_wr_enable  = (state_q == WRITE);
  assign o_wr_addr    = addr_q;
  assign o_data       = word_q;
  assign o_busy       = (state_q == RECEIVE) || (state_q == WRITE);
  assign o_done       = (state_q == DONE);
  assign o_overrun    = ovr_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: each task drives one scenario
// and checks outputs and the logged memory writes inline.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy, done, ovr;
  logic [5:0]  wcount;

  int cmp = 0;
  int err = 0;

  int          n_wr = 0;
  logic [4:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic        prev_we = 1'b0;
  int          n_dbl = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_wr_enable  (we),
    .o_wr_addr    (waddr),
    .o_data       (wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_overrun    (ovr),
    .o_word_count (wcount)
  );

  always @(posedge clk) begin
    if (we) begin
      if (n_wr < 64) begin
        log_addr[n_wr] = waddr;
        log_data[n_wr] = wdata;
      end
      n_wr = n_wr + 1;
    end
    if (we && prev_we) n_dbl = n_dbl + 1;
    prev_we = we;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset();
    do_reset();
    cmp++;
    if ({we, waddr, wdata, busy, done, ovr, wcount} !== '0) begin
      err++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h busy=%0b done=%0b ovr=%0b cnt=%0d, want all 0",
               we, waddr, wdata, busy, done, ovr, wcount);
    end
  endtask

  task automatic test_single_word();
    int base;
    do_reset();
    do_start();
    base = n_wr;
    cmp++;
    if (busy !== 1'b1) begin
      err++; $display("FAIL single_busy_start: got %0b want 1", busy);
    end
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== 32'h20010005) begin
      err++;
      $display("FAIL single_write: got we=%0b addr=%0d data=%h, want we=1 addr=0 data=20010005",
               we, waddr, wdata);
    end
    @(negedge clk);
    cmp++;
    if (wcount !== 6'd1 || busy !== 1'b1 || we !== 1'b0) begin
      err++;
      $display("FAIL single_after: got cnt=%0d busy=%0b we=%0b, want cnt=1 busy=1 we=0",
               wcount, busy, we);
    end
    cmp++;
    if (n_wr - base !== 1) begin
      err++; $display("FAIL single_nwrites: got %0d want 1", n_wr - base);
    end
  endtask

  task automatic test_halt();
    int base;
    do_reset();
    do_start();
    base = n_wr;
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'hFFFFFFFF);
    cmp++;
    if (done !== 1'b0 || we !== 1'b1) begin
      err++; $display("FAIL halt_write3: got done=%0b we=%0b want done=0 we=1", done, we);
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || wcount !== 6'd3) begin
      err++;
      $display("FAIL halt_done: got done=%0b busy=%0b cnt=%0d, want 1 0 3", done, busy, wcount);
    end
    cmp++;
    if (n_wr - base !== 3 ||
        log_addr[base] !== 5'd0 || log_data[base] !== 32'h1 ||
        log_addr[base+1] !== 5'd1 || log_data[base+1] !== 32'h2 ||
        log_addr[base+2] !== 5'd2 || log_data[base+2] !== 32'hFFFFFFFF) begin
      err++;
      $display("FAIL halt_log: got n=%0d a0=%0d a1=%0d a2=%0d d2=%h, want n=3 a=0,1,2 d2=ffffffff",
               n_wr - base, log_addr[base], log_addr[base+1], log_addr[base+2], log_data[base+2]);
    end
    send_word(32'h12345678);
    @(negedge clk);
    cmp++;
    if (n_wr - base !== 3 || done !== 1'b1 || ovr !== 1'b0 || waddr !== 5'd2) begin
      err++;
      $display("FAIL halt_ignore: got n=%0d done=%0b ovr=%0b addr=%0d, want 3 1 0 2",
               n_wr - base, done, ovr, waddr);
    end
  endtask

  task automatic test_full();
    int base;
    int bad;
    do_reset();
    do_start();
    base = n_wr;
    for (int i = 0; i < 30; i++) send_word(32'(i));
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || wcount !== 6'd30 || waddr !== 5'd29) begin
      err++;
      $display("FAIL full_done: got done=%0b cnt=%0d addr=%0d, want 1 30 29", done, wcount, waddr);
    end
    bad = 0;
    for (int i = 0; i < 30; i++)
      if (log_addr[base+i] !== 5'(i) || log_data[base+i] !== 32'(i)) bad++;
    cmp++;
    if (n_wr - base !== 30 || bad != 0) begin
      err++;
      $display("FAIL full_log: got n=%0d bad=%0d, want n=30 bad=0", n_wr - base, bad);
    end
    send_word(32'h0000001E);
    @(negedge clk);
    cmp++;
    if (n_wr - base !== 30) begin
      err++; $display("FAIL full_nowrap: got n=%0d want 30", n_wr - base);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    do_start();
    send_word(32'hFFFFFFFF);
    rx_data = 8'h55; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    cmp++;
    if (ovr !== 1'b1 || done !== 1'b1) begin
      err++; $display("FAIL overrun_set: got ovr=%0b done=%0b want 1 1", ovr, done);
    end
    send_byte(8'h77);
    cmp++;
    if (ovr !== 1'b1) begin
      err++; $display("FAIL overrun_sticky: got %0b want 1", ovr);
    end
    do_start();
    cmp++;
    if (ovr !== 1'b0 || busy !== 1'b1 || wcount !== 6'd0 || waddr !== 5'd0) begin
      err++;
      $display("FAIL overrun_clear: got ovr=%0b busy=%0b cnt=%0d addr=%0d, want 0 1 0 0",
               ovr, busy, wcount, waddr);
    end
  endtask

  task automatic test_reset_abort();
    int base;
    do_reset();
    do_start();
    base = n_wr;
    send_word(32'hA1A2A3A4);
    send_byte(8'hB1);
    send_byte(8'hB2);
    do_reset();
    cmp++;
    if ({we, waddr, wdata, busy, done, ovr, wcount} !== '0) begin
      err++;
      $display("FAIL abort_outputs: got we=%0b addr=%0d data=%h busy=%0b done=%0b cnt=%0d, want all 0",
               we, waddr, wdata, busy, done, wcount);
    end
    send_byte(8'hB3);
    send_byte(8'hB4);
    cmp++;
    if (n_wr - base !== 1) begin
      err++; $display("FAIL abort_nowrite: got n=%0d want 1", n_wr - base);
    end
    do_start();
    send_word(32'hC0DE0001);
    cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== 32'hC0DE0001) begin
      err++;
      $display("FAIL abort_restart: got we=%0b addr=%0d data=%h, want 1 0 c0de0001", we, waddr, wdata);
    end
  endtask

  task automatic test_idle_bytes();
    int base;
    do_reset();
    base = n_wr;
    send_byte(8'hAA);
    send_byte(8'hBB);
    cmp++;
    if (busy !== 1'b0 || n_wr !== base || wdata !== 32'h0) begin
      err++;
      $display("FAIL idle_ignore: got busy=%0b n=%0d data=%h, want 0 0 0", busy, n_wr - base, wdata);
    end
    do_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cmp++;
    if (we !== 1'b0) begin
      err++; $display("FAIL idle_early_write: got we=%0b want 0", we);
    end
    send_byte(8'h44);
    cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== 32'h11223344) begin
      err++;
      $display("FAIL idle_word0: got we=%0b addr=%0d data=%h, want 1 0 11223344", we, waddr, wdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_halt();
    test_full();
    test_overrun();
    test_reset_abort();
    test_idle_bytes();
    @(negedge clk);
    cmp++;
    if (n_dbl !== 0) begin
      err++; $display("FAIL strobe_single: got %0d back-to-back strobes want 0", n_dbl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
